fetch_decode_unit: RTL and testbench

Parametrised fetch/decode/indirect-address controller for the basic-computer datapath. It replaces the separate edge-triggered PC, AR, IR and I storage with one synchronous unit. It sequences PC->AR, M[AR]->IR, decode, and the optional indirect cycle against a variable-latency memory handshake. It then presents the effective address and decoded opcode to the execute stage.

---
 rtl/fetch_decode_unit_if.sv | 25 ++
 rtl/fetch_decode_unit.sv | 139 +++++++++++++
 tb/tb_fetch_decode_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_unit_if.sv
// Memory read bus between the fetch/decode unit and instruction memory.
// The master issues mem_rd/mem_addr; the slave answers with mem_valid/mem_rdata.
interface fetch_decode_unit_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_rdata,
        input  mem_valid
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_rdata,
        output mem_valid
    );
endinterface

// File: rtl/fetch_decode_unit.sv
// Fetch/decode/indirect-address controller: PC->AR, M[AR]->IR, decode, indirect.
// Optional FDU_PERF_CNT_EN adds instr_cnt/ind_cnt performance counters.
module fetch_decode_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int OPC_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                halt_req,
    fetch_decode_unit_if.master bus,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [ADDR_W-1:0]   ar_out,
    output logic [DATA_W-1:0]   ir_out,
    output logic                i_out,
    output logic [OPC_W-1:0]    opcode,
    output logic [2**OPC_W-1:0] decode_d,
    output logic                ea_valid,
    input  logic                ea_ack
`ifdef FDU_PERF_CNT_EN
    ,
    output logic [31:0]         instr_cnt,
    output logic [31:0]         ind_cnt
`endif
);

    generate
        if (1 + OPC_W + ADDR_W != DATA_W) begin : g_bad_widths
            $error("fetch_decode_unit: 1+OPC_W+ADDR_W must equal DATA_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        READ,
        DECODE,
        INDIRECT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ar;
    logic [DATA_W-1:0] ir;
    logic              ind;

    logic [OPC_W-1:0]  opc;
    logic              ind_cycle;

    assign opc       = ir[DATA_W-2 -: OPC_W];
    // All-ones opcode is register-reference/IO and never takes an indirect cycle.
    assign ind_cycle = ir[DATA_W-1] && (opc != {OPC_W{1'b1}});

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = FETCH;
            FETCH:    state_nxt = READ;
            READ:     if (bus.mem_valid) state_nxt = DECODE;
            DECODE:   state_nxt = ind_cycle ? INDIRECT : DONE;
            INDIRECT: if (bus.mem_valid) state_nxt = DONE;
            DONE: begin
                if (ea_ack) state_nxt = halt_req ? IDLE : FETCH;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the current state and IR
    always_comb begin
        bus.mem_rd = (state == READ) || (state == INDIRECT);
        ea_valid   = (state == DONE);
        decode_d   = '0;
        if (state != IDLE) decode_d[opc] = 1'b1;
    end

    // PC, AR, IR and I register transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= '0;
            ar  <= '0;
            ir  <= '0;
            ind <= 1'b0;
        end else begin
            case (state)
                FETCH: ar <= pc;
                READ: begin
                    if (bus.mem_valid) begin
                        ir <= bus.mem_rdata;
                        pc <= pc + ADDR_W'(1);
                    end
                end
                DECODE: begin
                    ar  <= ir[ADDR_W-1:0];
                    ind <= ir[DATA_W-1];
                end
                INDIRECT: begin
                    if (bus.mem_valid) ar <= bus.mem_rdata[ADDR_W-1:0];
                end
                default: ;
            endcase
        end
    end

`ifdef FDU_PERF_CNT_EN
    // Retired-instruction and indirect-cycle counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt <= '0;
            ind_cnt   <= '0;
        end else begin
            if (state == DONE && ea_ack) instr_cnt <= instr_cnt + 32'd1;
            if (state == INDIRECT && bus.mem_valid) ind_cnt <= ind_cnt + 32'd1;
        end
    end
`endif

    assign bus.mem_addr = ar;
    assign pc_out       = pc;
    assign ar_out       = ar;
    assign ir_out       = ir;
    assign i_out        = ind;
    assign opcode       = opc;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed testbench for fetch_decode_unit.
// Memory responses are driven by hand, step by step.
module tb_fetch_decode_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt_req;
    logic [11:0] pc_out;
    logic [11:0] ar_out;
    logic [15:0] ir_out;
    logic        i_out;
    logic [2:0]  opcode;
    logic [7:0]  decode_d;
    logic        ea_valid;
    logic        ea_ack;
`ifdef FDU_PERF_CNT_EN
    logic [31:0] instr_cnt;
    logic [31:0] ind_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    fetch_decode_unit_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    fetch_decode_unit #(.DATA_W(16), .ADDR_W(12), .OPC_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .halt_req (halt_req),
        .bus      (bus.master),
        .pc_out   (pc_out),
        .ar_out   (ar_out),
        .ir_out   (ir_out),
        .i_out    (i_out),
        .opcode   (opcode),
        .decode_d (decode_d),
        .ea_valid (ea_valid),
        .ea_ack   (ea_ack)
`ifdef FDU_PERF_CNT_EN
        ,
        .instr_cnt(instr_cnt),
        .ind_cnt  (ind_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bit reached;
        rst = 1'b1;
        start = 1'b0;
        halt_req = 1'b0;
        ea_ack = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        #2;
        chk("rst_pc", 32'(pc_out), 32'h0);
        chk("rst_ar", 32'(ar_out), 32'h0);
        chk("rst_ir", 32'(ir_out), 32'h0);
        chk("rst_i", 32'(i_out), 32'h0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
        chk("rst_ea_valid", 32'(ea_valid), 32'h0);
        chk("rst_decode_d", 32'(decode_d), 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("idle_mem_rd", 32'(bus.mem_rd), 32'h0);

        // Direct fetch, zero-wait memory
        start = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 16'h2005;
        step();
        start = 1'b0;
        chk("d_fetch_ea", 32'(ea_valid), 32'h0);
        step();
        chk("d_read_rd", 32'(bus.mem_rd), 32'h1);
        chk("d_read_addr", 32'(bus.mem_addr), 32'h000);
        step();
        bus.mem_valid = 1'b0;
        chk("d_dec_ea", 32'(ea_valid), 32'h0);
        chk("d_dec_ir", 32'(ir_out), 32'h2005);
        step();
        chk("d_ea_valid", 32'(ea_valid), 32'h1);
        chk("d_ar", 32'(ar_out), 32'h005);
        chk("d_opcode", 32'(opcode), 32'h2);
        chk("d_decode_d", 32'(decode_d), 32'h04);
        chk("d_i", 32'(i_out), 32'h0);
        chk("d_pc", 32'(pc_out), 32'h001);

        // Indirect: M[1]=0x9010, M[0x010]=0x0123
        ea_ack = 1'b1;
        step();
        ea_ack = 1'b0;
        chk("n_fetch_ea", 32'(ea_valid), 32'h0);
        step();
        chk("n_read_addr", 32'(bus.mem_addr), 32'h001);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 16'h9010;
        step();
        bus.mem_valid = 1'b0;
        step();
        chk("n_ind_rd", 32'(bus.mem_rd), 32'h1);
        chk("n_ind_addr", 32'(bus.mem_addr), 32'h010);
        chk("n_ind_ea", 32'(ea_valid), 32'h0);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 16'h0123;
        step();
        bus.mem_valid = 1'b0;
        chk("n_ea_valid", 32'(ea_valid), 32'h1);
        chk("n_ar", 32'(ar_out), 32'h123);
        chk("n_i", 32'(i_out), 32'h1);
        chk("n_opcode", 32'(opcode), 32'h1);
        chk("n_decode_d", 32'(decode_d), 32'h02);
        chk("n_pc", 32'(pc_out), 32'h002);

        // Register-reference with I=1: indirect skipped
        ea_ack = 1'b1;
        step();
        ea_ack = 1'b0;
        step();
        chk("r_read_addr", 32'(bus.mem_addr), 32'h002);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 16'hF800;
        step();
        bus.mem_valid = 1'b0;
        step();
        chk("r_ea_valid", 32'(ea_valid), 32'h1);
        chk("r_mem_rd", 32'(bus.mem_rd), 32'h0);
        chk("r_ar", 32'(ar_out), 32'h800);
        chk("r_decode_d", 32'(decode_d), 32'h80);
        chk("r_i", 32'(i_out), 32'h1);
        chk("r_pc", 32'(pc_out), 32'h003);

        // Run zero-wait fetches of 0x0000 until PC reaches 0xFFF
        bus.mem_rdata = 16'h0000;
        bus.mem_valid = 1'b1;
        ea_ack = 1'b1;
        reached = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            step();
            if (ea_valid && pc_out == 12'hFFF) begin
                reached = 1'b1;
                break;
            end
        end
        chk("w_pc_reached", 32'(reached), 32'h1);
        bus.mem_valid = 1'b0;
        step();
        ea_ack = 1'b0;
        step();
        bus.mem_rdata = 16'h3007;
        for (int i = 0; i < 4; i++) begin
            chk("w_rd_stable", 32'(bus.mem_rd), 32'h1);
            chk("w_addr_stable", 32'(bus.mem_addr), 32'hFFF);
            if (i == 3) bus.mem_valid = 1'b1;
            step();
        end
        bus.mem_valid = 1'b0;
        chk("w_pc_wrap", 32'(pc_out), 32'h000);
        step();
        chk("w_ea_valid", 32'(ea_valid), 32'h1);
        chk("w_ar", 32'(ar_out), 32'h007);

        // Hold in DONE without ack, then halt
        for (int i = 0; i < 5; i++) begin
            chk("h_ea_hold", 32'(ea_valid), 32'h1);
            chk("h_ar_hold", 32'(ar_out), 32'h007);
            chk("h_ir_hold", 32'(ir_out), 32'h3007);
            chk("h_dd_hold", 32'(decode_d), 32'h08);
            step();
        end
        ea_ack = 1'b1;
        halt_req = 1'b1;
        step();
        ea_ack = 1'b0;
        halt_req = 1'b0;
        chk("h_idle_ea", 32'(ea_valid), 32'h0);
        chk("h_idle_dd", 32'(decode_d), 32'h00);
        for (int i = 0; i < 3; i++) begin
            chk("h_idle_rd", 32'(bus.mem_rd), 32'h0);
            step();
        end

        // start and halt_req together: start wins
        start = 1'b1;
        halt_req = 1'b1;
        step();
        start = 1'b0;
        halt_req = 1'b0;
        step();
        chk("s_read_rd", 32'(bus.mem_rd), 32'h1);
        chk("s_read_addr", 32'(bus.mem_addr), 32'h000);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 16'h8123;
        step();
        bus.mem_valid = 1'b0;
        step();
        chk("a_ind_rd", 32'(bus.mem_rd), 32'h1);
        chk("a_ind_addr", 32'(bus.mem_addr), 32'h123);
`ifdef FDU_PERF_CNT_EN
        chk("a_ind_cnt_pre", ind_cnt, 32'd1);
`endif

        // Async reset mid-INDIRECT
        #2;
        rst = 1'b1;
        #1;
        chk("a_mem_rd", 32'(bus.mem_rd), 32'h0);
        chk("a_ea_valid", 32'(ea_valid), 32'h0);
        chk("a_pc", 32'(pc_out), 32'h000);
        chk("a_ar", 32'(ar_out), 32'h000);
        chk("a_decode_d", 32'(decode_d), 32'h00);
`ifdef FDU_PERF_CNT_EN
        chk("a_instr_cnt", instr_cnt, 32'd0);
        chk("a_ind_cnt", ind_cnt, 32'd0);
`endif
        step();
        rst = 1'b0;
        step();
        chk("a_post_rd", 32'(bus.mem_rd), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
